// File: rtl/icache_axi_refill.sv
`default_nettype none
// ============================================================================
// Module      : icache_axi_refill
// Description : Single-outstanding AXI4 INCR read-burst line refill engine
//               between the ICache miss FSM and the AXI read channels.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_axi_refill #(
    parameter int         OFFSET_LEN = 5,
    parameter logic [3:0] AXI_ID     = 4'h0,
    localparam int        c_WORDS    = 1 << (OFFSET_LEN - 2)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rd_req,
    input  logic [31:0]               rd_addr,
    output logic                      gnt,
    output logic [c_WORDS-1:0][31:0]  line_data,
    output logic                      rd_err,
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int                 c_IDX_W = OFFSET_LEN - 2;
    localparam int                 c_CNT_W = c_IDX_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(c_WORDS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               w_beat_err;
    logic               w_unused;

    assign arid     = AXI_ID;
    assign arlen    = 8'(c_WORDS - 1);
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign w_unused = &{1'b0, rd_addr[OFFSET_LEN-1:0]};

    // Error contribution of the beat currently on the R channel: bad response,
    // overflow beyond the line, or rlast arriving on the wrong beat.
    always_comb begin
        w_beat_err = 1'b0;
        if (rresp != 2'b00)
            w_beat_err = 1'b1;
        if (r_cnt >= c_FULL)
            w_beat_err = 1'b1;
        if (rlast && (r_cnt != c_LAST))
            w_beat_err = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            gnt       <= 1'b0;
            rd_err    <= 1'b0;
            araddr    <= '0;
            line_data <= '0;
        end else begin
            gnt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd_req) begin
                        araddr  <= {rd_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        arvalid <= 1'b1;
                        r_state <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        if (r_cnt < c_FULL) begin
                            line_data[r_cnt[c_IDX_W-1:0]] <= rdata;
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (w_beat_err)
                            r_err <= 1'b1;
                        // Words not delivered by a short burst keep their old value.
                        if (rlast) begin
                            rready  <= 1'b0;
                            gnt     <= 1'b1;
                            rd_err  <= r_err | w_beat_err;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- AXI4 read-burst refill engine that sits directly downstream of the instruction cache.
- Accepts one line-refill request (line-aligned address) from the ICache miss FSM and issues a single 8-beat INCR burst on the AXI AR channel.
- Collects the R-channel beats into an 8-word line buffer, then returns the line with a one-cycle grant pulse.
- Handles one outstanding refill at a time.

Parameters:
- OFFSET_LEN, 5, log2 of line size in bytes; words per line = 1<<(OFFSET_LEN-2) = 8.
- AXI_ID, 4'h0, value driven on arid.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rd_req  in  1  refill request from ICache; held high until gnt
- rd_addr  in  32  miss address; bits [OFFSET_LEN-1:0] ignored
- gnt  out  1  one-cycle pulse: line_data valid and complete
- line_data  out  32x8  refilled line; word i = address base+4i
- rd_err  out  1  valid with gnt; set if any rresp!=OKAY or beat-count/rlast mismatch
- arid  out  4  = AXI_ID
- araddr  out  32  {rd_addr[31:OFFSET_LEN], OFFSET_LEN'b0}, registered
- arlen  out  8  constant 7
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset (resetn=0, async): state=IDLE; arvalid=0, rready=0, gnt=0, rd_err=0, araddr=0, beat counter=0, line_data=all 0.
- Reset mid-burst: abandon the transfer immediately; no gnt is produced.
- State IDLE:
  - rd_req=1 → latch aligned address into araddr, clear error flag and beat counter, go to AR.
  - arvalid rises the cycle after rd_req is sampled high.
- State AR:
  - arvalid=1; araddr stable until handshake.
  - arvalid&&arready → go to R; arvalid=0 next cycle.
- State R:
  - rready=1.
  - Each rvalid&&rready beat:
    - If counter<8: write rdata into line_data[counter]; counter++.
    - Beats beyond the 8th are discarded and set the error flag.
    - rresp!=2'b00 on any beat sets the error flag.
  - Beat with rlast=1 → go to DONE; rready=0 next cycle.
    - If that beat is not the 8th, set the error flag.
    - Words not received keep their previous value.
  - Beats with rvalid=0 leave the counter unchanged; arbitrary stalls between beats are allowed.
- State DONE (one cycle):
  - gnt=1, rd_err=error flag.
  - line_data holds stable from DONE until the next request leaves IDLE.
  - Next state IDLE.
- Latency (zero-wait slave, arready=1, rvalid=1 continuous): rd_req high at cycle 0 → arvalid cycle 1 → beats cycles 2..9 → gnt cycle 10.
- rd_req still high in the IDLE cycle after gnt starts a new refill. The ICache drops rd_req on the cycle it samples gnt, so this does not occur in normal operation.
- rd_addr changes while not in IDLE are ignored; araddr is fixed once latched.
- rid is not checked (single outstanding ID).
- arlen, arsize, arburst and arid are constants, valid in all states.
- gnt is never asserted in any state other than DONE; never two consecutive cycles.

Test Plan:
- Basic refill: rd_req=1, rd_addr=0x1FC0_0124, zero-wait slave returns 0xA0..0xA7 → araddr=0x1FC0_0120, arlen=7, gnt at cycle 10, line_data[0..7]=0xA0..0xA7, rd_err=0.
- Backpressure: arready low 3 cycles, rvalid gaps after beats 2 and 5 → araddr stable while arvalid=1, correct word order, gnt exactly 1 cycle after the rlast beat.
- Error response: rresp=2'b10 on beat 4 → all 8 words captured, gnt with rd_err=1; next clean refill gives rd_err=0.
- Short burst: rlast on 6th beat → gnt with rd_err=1, line_data[6..7] unchanged from the previous line.
- Reset mid-operation: resetn low during beat 3 → arvalid/rready/gnt immediately 0, line_data=0; request after reset completes normally.
- Back-to-back requests: two refills 0x0000_1000 and 0x0000_2040 → two separate AR handshakes, two single-cycle gnt pulses, second line overwrites the first.
